// File: rtl/seq_logic_pkg.sv
// Shared encodings and helpers for the sliced bitwise logic unit.
package seq_logic_pkg;

  typedef enum logic [1:0] {
    LOGIC_AND = 2'b00,
    LOGIC_OR  = 2'b01,
    LOGIC_XOR = 2'b10,
    LOGIC_NOR = 2'b11
  } logic_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  // Slice counter width: clog2(n), never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_logic_unit_if.sv
// Start/busy/done handshake and operand/result bus of the sliced logic unit.
interface seq_logic_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, zero
  );
endinterface

// File: rtl/logic_slice.sv
// Combinational SLICE-bit AND/OR/XOR/NOR cell, reused once per cycle by the top.
module logic_slice
  import seq_logic_pkg::*;
#(
  parameter int unsigned SLICE = 4
) (
  input  logic_op_e        op_i,
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  output logic [SLICE-1:0] y_o
);

  always_comb begin
    y_o = '0;
    unique case (op_i)
      LOGIC_AND: y_o = a_i & b_i;
      LOGIC_OR:  y_o = a_i | b_i;
      LOGIC_XOR: y_o = a_i ^ b_i;
      LOGIC_NOR: y_o = ~(a_i | b_i);
    endcase
  end

endmodule

// File: rtl/seq_logic_unit.sv
// Multi-cycle bitwise logic unit: one SLICE-bit slice per clock, LSB slice first.
module seq_logic_unit
  import seq_logic_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 4
) (
  input  logic              clk,
  input  logic              reset,
  seq_logic_unit_if.slave   bus
);

  localparam int unsigned N    = WIDTH / SLICE;
  localparam int unsigned CntW = cnt_width(N);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic_op_e        op_q;
  logic             busy_q, done_q, zero_q;

  logic [N-1:0][SLICE-1:0] a_arr, b_arr, res_arr;
  logic [SLICE-1:0]        a_sl, b_sl, y_sl;
  logic [WIDTH-1:0]        result_nx;

  // Slice selection via packed arrays keeps index widths exact.
  always_comb begin
    a_arr          = a_q;
    b_arr          = b_q;
    a_sl           = a_arr[cnt_q];
    b_sl           = b_arr[cnt_q];
    res_arr        = result_q;
    res_arr[cnt_q] = y_sl;
    result_nx      = res_arr;
  end

  logic_slice #(
    .SLICE(SLICE)
  ) u_slice (
    .op_i(op_q),
    .a_i (a_sl),
    .b_i (b_sl),
    .y_o (y_sl)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= LOGIC_AND;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            state_q  <= StRun;
            a_q      <= bus.a;
            b_q      <= bus.b;
            op_q     <= logic_op_e'(bus.op);
            result_q <= '0;
            cnt_q    <= '0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          result_q <= result_nx;
          if (cnt_q == LastCnt) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            zero_q  <= (result_nx == '0);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_seq_logic_unit.sv
// Scoreboard bench: directed and random ops on three parametrisations of seq_logic_unit.
module tb_seq_logic_unit;
  import seq_logic_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seq_logic_unit_if #(.WIDTH(32)) bus32 ();
  seq_logic_unit_if #(.WIDTH(8))  bus8  ();
  seq_logic_unit_if #(.WIDTH(16)) bus16 ();

  seq_logic_unit #(.WIDTH(32), .SLICE(4)) u_dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
  seq_logic_unit #(.WIDTH(8),  .SLICE(8)) u_dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));
  seq_logic_unit #(.WIDTH(16), .SLICE(2)) u_dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    int unsigned when;
  } exp_t;

  exp_t q32[$], q8[$], q16[$];
  exp_t e32, e8, e16;

  function automatic logic [31:0] model(logic [1:0] op, logic [31:0] a, logic [31:0] b, int w);
    logic [31:0] r;
    logic [31:0] m;
    case (op)
      2'd0:    r = a & b;
      2'd1:    r = a | b;
      2'd2:    r = a ^ b;
      default: r = ~(a | b);
    endcase
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return r & m;
  endfunction

  // Expected done is observed N cycles after the accept edge, which is the next edge.
  function automatic exp_t mk(logic [1:0] op, logic [31:0] a, logic [31:0] b, int w, int n);
    exp_t e;
    e.res  = model(op, a, b, w);
    e.zero = (e.res == 32'd0);
    e.when = cyc + 1 + n;
    return e;
  endfunction

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endfunction

  // Monitor: pops on every done pulse, independent of the stimulus.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus32.busy || bus32.done) chk("busy_done_excl32", 32'(bus32.busy & bus32.done), 0);
      if (bus32.done) begin
        chk("pending32", 32'(q32.size() > 0), 1);
        if (q32.size() > 0) begin
          e32 = q32.pop_front();
          chk("result32", bus32.result, e32.res);
          chk("zero32", 32'(bus32.zero), 32'(e32.zero));
          chk("latency32", cyc, e32.when);
        end
      end
      if (bus8.done) begin
        chk("pending8", 32'(q8.size() > 0), 1);
        if (q8.size() > 0) begin
          e8 = q8.pop_front();
          chk("result8", 32'(bus8.result), e8.res);
          chk("zero8", 32'(bus8.zero), 32'(e8.zero));
          chk("latency8", cyc, e8.when);
        end
      end
      if (bus16.done) begin
        chk("pending16", 32'(q16.size() > 0), 1);
        if (q16.size() > 0) begin
          e16 = q16.pop_front();
          chk("result16", 32'(bus16.result), e16.res);
          chk("zero16", 32'(bus16.zero), 32'(e16.zero));
          chk("latency16", cyc, e16.when);
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue32(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    bus32.start = 1'b1; bus32.op = op; bus32.a = a; bus32.b = b;
    q32.push_back(mk(op, a, b, 32, 8));
    tick(1);
    bus32.start = 1'b0;
  endtask

  task automatic issue8(logic [1:0] op, logic [7:0] a, logic [7:0] b);
    bus8.start = 1'b1; bus8.op = op; bus8.a = a; bus8.b = b;
    q8.push_back(mk(op, 32'(a), 32'(b), 8, 1));
    tick(1);
    bus8.start = 1'b0;
  endtask

  task automatic issue16(logic [1:0] op, logic [15:0] a, logic [15:0] b);
    bus16.start = 1'b1; bus16.op = op; bus16.a = a; bus16.b = b;
    q16.push_back(mk(op, 32'(a), 32'(b), 16, 8));
    tick(1);
    bus16.start = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((q32.size() + q8.size() + q16.size()) != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("drain_outstanding", 32'(q32.size() + q8.size() + q16.size()), 0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    exp_t        first;

    bus32.start = 1'b0; bus32.op = 2'd0; bus32.a = '0; bus32.b = '0;
    bus8.start  = 1'b0; bus8.op  = 2'd0; bus8.a  = '0; bus8.b  = '0;
    bus16.start = 1'b0; bus16.op = 2'd0; bus16.a = '0; bus16.b = '0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    chk("rst_busy", 32'(bus32.busy), 0);
    chk("rst_done", 32'(bus32.done), 0);
    chk("rst_result", bus32.result, 0);
    chk("rst_zero", 32'(bus32.zero), 0);
    tick(2);

    // AND
    issue32(2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00);
    chk("busy_after_accept", 32'(bus32.busy), 1);
    drain();
    chk("and_result_hold", bus32.result, 32'hF000_F000);

    // NOR both ways
    issue32(2'b11, 32'h0, 32'h0);
    drain();
    issue32(2'b11, 32'hFFFF_FFFF, 32'h1234_5678);
    drain();
    tick(2);
    chk("nor_zero_hold", 32'(bus32.zero), 1);
    chk("nor_result_hold", bus32.result, 32'h0);

    // XOR with an ignored start pulse carrying new op/operands at RUN cycle 3
    issue32(2'b10, 32'hAAAA_5555, 32'hFFFF_0000);
    tick(2);
    bus32.start = 1'b1; bus32.op = 2'b01; bus32.a = 32'h1357_9BDF; bus32.b = 32'h0F0F_0000;
    tick(1);
    bus32.start = 1'b0;
    drain();
    chk("xor_result_hold", bus32.result, 32'h5555_5555);

    // Reset mid-operation: no done pulse may follow
    issue32(2'b01, 32'h0000_00F0, 32'h0F00_0000);
    tick(3);
    reset = 1'b1;
    q32.delete();
    tick(1);
    reset = 1'b0;
    chk("abort_busy", 32'(bus32.busy), 0);
    chk("abort_done", 32'(bus32.done), 0);
    chk("abort_result", bus32.result, 0);
    chk("abort_zero", 32'(bus32.zero), 0);
    tick(12);
    chk("abort_stays_idle", 32'(bus32.busy), 0);

    // Back-to-back: start held high, second op accepted in the DONE cycle
    bus32.start = 1'b1; bus32.op = 2'b01; bus32.a = 32'h0F0F_0F0F; bus32.b = 32'hF0F0_F0F0;
    first = mk(2'b01, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32, 8);
    q32.push_back(first);
    tick(1);
    bus32.op = 2'b00; bus32.a = 32'h0; bus32.b = 32'h1;
    q32.push_back('{res: 32'h0, zero: 1'b1, when: first.when + 9});
    tick(9);
    bus32.start = 1'b0;
    drain();

    // N=1 and SLICE=2 parametrisations
    issue8(2'b10, 8'hA5, 8'h5A);
    drain();
    issue8(2'b00, 8'hF0, 8'h0F);
    drain();
    issue16(2'b11, 16'h00FF, 16'h0F0F);
    drain();
    chk("w16_nor_hold", 32'(bus16.result), 32'h0000_F000);

    // Random ops, with occasional ignored start pulses during RUN
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ~ra;
        default: rb = $urandom;
      endcase
      issue32(rop, ra, rb);
      if ($urandom_range(0, 1) == 1) begin
        tick($urandom_range(1, 5));
        bus32.start = 1'b1; bus32.op = 2'($urandom); bus32.a = $urandom; bus32.b = $urandom;
        tick(1);
        bus32.start = 1'b0;
      end
      drain();
      tick($urandom_range(0, 2));
    end

    for (int i = 0; i < 8; i++) begin
      issue8(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      issue16(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
